// File: rtl/sram_like_bridge.sv
// Request/response front end that turns a stage request into an sram-like
// req/addr_ok/data_ok transaction. Responses are returned in order through a small FIFO.
module sram_like_bridge #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MAX_OUT    = 2,
    parameter int unsigned RESP_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [1:0]            req_size,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic                  flush,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_wr,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  bus_req,
    output logic                  bus_wr,
    output logic [1:0]            bus_size,
    output logic [DATA_W/8-1:0]   bus_wstrb,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_addr_ok,
    input  logic                  bus_data_ok,
    input  logic [DATA_W-1:0]     bus_rdata,
    output logic                  idle,
    output logic                  err
);

    localparam int unsigned IW = $clog2(MAX_OUT + 1);
    localparam int unsigned FW = $clog2(RESP_DEPTH + 1);
    localparam int unsigned PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int unsigned OW = $clog2(MAX_OUT + RESP_DEPTH + 1);

    logic [IW-1:0]      r_inflight, w_inflight_d;
    logic [IW-1:0]      r_discard, w_discard_d;
    logic [MAX_OUT-1:0] r_wrq, w_wrq_d;
    logic [FW-1:0]      r_count, w_count_d;
    logic [PW-1:0]      r_wptr, w_wptr_d;
    logic [PW-1:0]      r_rptr, w_rptr_d;
    logic               r_err;
    logic [DATA_W:0]    r_mem [RESP_DEPTH];

    logic               w_credit, w_hs, w_dok, w_push, w_pop;
    logic [OW-1:0]      w_occ;
    logic [DATA_W-1:0]  w_push_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Every accepted request is guaranteed a FIFO slot, so data_ok never stalls.
    assign w_occ    = OW'(r_inflight) + OW'(r_count);
    assign w_credit = resetn && !flush && (r_inflight < IW'(MAX_OUT))
                      && (w_occ < OW'(RESP_DEPTH));

    assign bus_req   = req_valid && w_credit;
    assign bus_wr    = req_wr;
    assign bus_size  = req_size;
    assign bus_wstrb = req_wstrb;
    assign bus_addr  = req_addr;
    assign bus_wdata = req_wdata;
    assign w_hs      = bus_req && bus_addr_ok;
    assign req_ready = w_hs;

    assign w_dok       = bus_data_ok && (r_inflight != '0);
    assign w_push      = w_dok && !flush && (r_discard == '0);
    assign w_pop       = resp_valid && resp_ready && !flush;
    assign w_push_data = r_wrq[0] ? '0 : bus_rdata;

    assign resp_valid = (r_count != '0);
    assign resp_wr    = r_mem[r_rptr][DATA_W];
    assign resp_rdata = r_mem[r_rptr][DATA_W-1:0];
    assign idle       = (r_inflight == '0) && (r_count == '0) && (r_discard == '0);
    assign err        = r_err;

    always_comb begin
        w_inflight_d = r_inflight + IW'(w_hs) - IW'(w_dok);
        w_wrq_d      = w_dok ? (r_wrq >> 1) : r_wrq;
        for (int i = 0; i < MAX_OUT; i++) begin
            if (w_hs && (IW'(i) == r_inflight - IW'(w_dok))) begin
                w_wrq_d[i] = req_wr;
            end
        end

        w_discard_d = r_discard;
        if (flush) begin
            // Everything in flight is cancelled; discard already counts a subset of it.
            w_discard_d = r_inflight - IW'(w_dok);
        end else if (w_dok && (r_discard != '0)) begin
            w_discard_d = r_discard - IW'(1);
        end

        w_wptr_d  = r_wptr;
        w_rptr_d  = r_rptr;
        w_count_d = r_count;
        if (flush) begin
            w_rptr_d  = r_wptr;
            w_count_d = '0;
        end else begin
            if (w_push) w_wptr_d = ptr_inc(r_wptr);
            if (w_pop)  w_rptr_d = ptr_inc(r_rptr);
            w_count_d = r_count + FW'(w_push) - FW'(w_pop);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_inflight <= '0;
            r_discard  <= '0;
            r_wrq      <= '0;
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_err      <= 1'b0;
        end else begin
            r_inflight <= w_inflight_d;
            r_discard  <= w_discard_d;
            r_wrq      <= w_wrq_d;
            r_count    <= w_count_d;
            r_wptr     <= w_wptr_d;
            r_rptr     <= w_rptr_d;
            if (bus_data_ok && (r_inflight == '0)) r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {r_wrq[0], w_push_data};
    end

endmodule

// File: tb/tb_sram_like_bridge.sv
// Randomized bench for sram_like_bridge: a queue-based model of in-flight requests and
// buffered responses is compared with the DUT every cycle, plus directed literal checks.
module tb_sram_like_bridge;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned MAX_OUT    = 2;
    localparam int unsigned RESP_DEPTH = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_ready, req_wr;
    logic [1:0]  req_size;
    logic [3:0]  req_wstrb;
    logic [31:0] req_addr, req_wdata;
    logic        flush;
    logic        resp_valid, resp_ready, resp_wr;
    logic [31:0] resp_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;
    logic        idle, err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sram_like_bridge #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MAX_OUT    (MAX_OUT),
        .RESP_DEPTH (RESP_DEPTH)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wr      (req_wr),
        .req_size    (req_size),
        .req_wstrb   (req_wstrb),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .flush       (flush),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_wr     (resp_wr),
        .resp_rdata  (resp_rdata),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_size    (bus_size),
        .bus_wstrb   (bus_wstrb),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .bus_rdata   (bus_rdata),
        .idle        (idle),
        .err         (err)
    );

    // Model: each outstanding request remembers its kind and whether a flush cancelled it.
    typedef struct packed {
        logic wr;
        logic cancel;
    } ent_t;

    ent_t        m_inf[$];
    logic [32:0] m_resp[$];
    logic        m_err = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_credit();
        return resetn && !flush && (m_inf.size() < MAX_OUT)
               && (m_inf.size() + m_resp.size() < RESP_DEPTH);
    endfunction

    function automatic logic m_idle();
        return (m_inf.size() == 0) && (m_resp.size() == 0);
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_inf.delete();
            m_resp.delete();
            m_err = 1'b0;
        end else begin
            logic hs;
            ent_t e;
            hs = req_valid && bus_addr_ok && m_credit();
            if (resp_ready && !flush && m_resp.size() != 0) void'(m_resp.pop_front());
            if (bus_data_ok) begin
                if (m_inf.size() == 0) begin
                    m_err = 1'b1;
                end else begin
                    e = m_inf.pop_front();
                    if (!flush && !e.cancel) m_resp.push_back({e.wr, e.wr ? 32'h0 : bus_rdata});
                end
            end
            if (flush) begin
                m_resp.delete();
                foreach (m_inf[i]) m_inf[i].cancel = 1'b1;
            end
            if (hs) begin
                e.wr     = req_wr;
                e.cancel = 1'b0;
                m_inf.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        logic exp_req;
        exp_req = req_valid && m_credit();
        chk("bus_req", 64'(bus_req), 64'(exp_req));
        chk("req_ready", 64'(req_ready), 64'(exp_req && bus_addr_ok));
        chk("resp_valid", 64'(resp_valid), 64'(m_resp.size() != 0));
        if (m_resp.size() != 0) chk("resp_head", 64'({resp_wr, resp_rdata}), 64'(m_resp[0]));
        chk("idle", 64'(idle), 64'(m_idle()));
        chk("err", 64'(err), 64'(m_err));
        if (exp_req) begin
            chk("bus_ctrl", 64'({bus_wr, bus_size, bus_wstrb, bus_addr}),
                64'({req_wr, req_size, req_wstrb, req_addr}));
            chk("bus_wdata", 64'(bus_wdata), 64'(req_wdata));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req_valid   = 1'b0;
        flush       = 1'b0;
        resp_ready  = 1'b1;
        bus_addr_ok = 1'b0;
        for (int i = 0; i < 50 && !m_idle(); i++) begin
            bus_data_ok = (m_inf.size() != 0);
            bus_rdata   = $urandom;
            step();
        end
        bus_data_ok = 1'b0;
        chk("drain_idle", 64'(idle), 64'(1));
    endtask

    initial begin
        int hs_cnt;
        resetn      = 1'b0;
        req_valid   = 1'b1;
        req_wr      = 1'b0;
        req_size    = 2'd2;
        req_wstrb   = 4'hf;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        flush       = 1'b0;
        resp_ready  = 1'b0;
        bus_addr_ok = 1'b1;
        bus_data_ok = 1'b0;
        bus_rdata   = 32'h0;

        // Reset values with a request pending on the input.
        #2;
        chk("rst_bus_req", 64'(bus_req), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_idle", 64'(idle), 64'(1));
        chk("rst_err", 64'(err), 64'(0));
        step();
        step();
        resetn    = 1'b1;
        req_valid = 1'b0;

        // Single read.
        step();
        req_valid = 1'b1;
        req_addr  = 32'h1c00_0000;
        @(negedge clk);
        chk("t1_hs", 64'(req_ready), 64'(1));
        step();
        req_valid   = 1'b0;
        bus_addr_ok = 1'b0;
        step();
        step();
        bus_data_ok = 1'b1;
        bus_rdata   = 32'hdead_beef;
        @(negedge clk);
        chk("t1_no_bypass", 64'(resp_valid), 64'(0));
        step();
        bus_data_ok = 1'b0;
        resp_ready  = 1'b1;
        @(negedge clk);
        chk("t1_resp", 64'({resp_valid, resp_wr, resp_rdata}), 64'({2'b10, 32'hdead_beef}));
        step();
        resp_ready = 1'b0;
        @(negedge clk);
        chk("t1_idle", 64'(idle), 64'(1));

        // Credit limit: only MAX_OUT handshakes without data_ok.
        step();
        req_valid   = 1'b1;
        bus_addr_ok = 1'b1;
        resp_ready  = 1'b1;
        hs_cnt      = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (req_ready) hs_cnt++;
            step();
        end
        chk("t2_hs_count", 64'(hs_cnt), 64'(2));
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h0bad_f00d;
        @(negedge clk);
        chk("t2_blocked", 64'(bus_req), 64'(0));
        step();
        bus_data_ok = 1'b0;
        @(negedge clk);
        chk("t2_fifo_holds", 64'(bus_req), 64'(0));
        step();
        @(negedge clk);
        chk("t2_reassert", 64'(bus_req), 64'(1));
        step();
        drain();

        // FIFO full blocks new requests until a pop.
        resp_ready  = 1'b0;
        req_valid   = 1'b1;
        bus_addr_ok = 1'b1;
        step();
        step();
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h1111_1111;
        step();
        bus_rdata   = 32'h2222_2222;
        step();
        bus_data_ok = 1'b0;
        resp_ready  = 1'b1;
        @(negedge clk);
        chk("t3_full_block", 64'(bus_req), 64'(0));
        chk("t3_head", 64'(resp_rdata), 64'(32'h1111_1111));
        step();
        resp_ready = 1'b0;
        @(negedge clk);
        chk("t3_one_slot", 64'(bus_req), 64'(1));
        step();
        @(negedge clk);
        chk("t3_full_again", 64'(bus_req), 64'(0));
        drain();

        // Flush with two in flight and data_ok in the flush cycle.
        req_valid   = 1'b1;
        bus_addr_ok = 1'b1;
        step();
        step();
        flush       = 1'b1;
        bus_data_ok = 1'b1;
        bus_rdata   = 32'haaaa_aaaa;
        @(negedge clk);
        chk("t4_flush_noreq", 64'(bus_req), 64'(0));
        step();
        flush       = 1'b0;
        bus_data_ok = 1'b0;
        @(negedge clk);
        chk("t4_after_flush", 64'({resp_valid, idle}), 64'(0));
        step();
        req_valid   = 1'b0;
        bus_data_ok = 1'b1;
        bus_rdata   = 32'hbbbb_bbbb;
        step();
        bus_rdata   = 32'h1234_5678;
        @(negedge clk);
        chk("t4_dropped", 64'(resp_valid), 64'(0));
        step();
        bus_data_ok = 1'b0;
        resp_ready  = 1'b1;
        @(negedge clk);
        chk("t4_delivered", 64'({resp_valid, resp_rdata}), 64'({1'b1, 32'h1234_5678}));
        step();
        @(negedge clk);
        chk("t4_idle", 64'(idle), 64'(1));

        // Streaming reads with simultaneous handshake, data_ok and pop.
        req_valid   = 1'b1;
        bus_addr_ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus_data_ok = (m_inf.size() != 0);
            bus_rdata   = $urandom;
            req_addr    = $urandom;
            step();
        end
        drain();

        // Spurious data_ok sets sticky err; async reset mid-transaction.
        bus_data_ok = 1'b1;
        step();
        bus_data_ok = 1'b0;
        @(negedge clk);
        chk("t6_err_set", 64'(err), 64'(1));
        step();
        step();
        chk("t6_err_sticky", 64'(err), 64'(1));
        req_valid   = 1'b1;
        bus_addr_ok = 1'b1;
        step();
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_async_rst", 64'({bus_req, req_ready, resp_valid, idle, err}), 64'(5'b00010));
        step();
        step();
        resetn = 1'b1;

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            req_valid   = ($urandom % 4) != 0;
            req_wr      = $urandom % 2;
            req_size    = 2'($urandom % 3);
            req_wstrb   = 4'($urandom);
            req_addr    = $urandom;
            req_wdata   = $urandom;
            bus_addr_ok = ($urandom % 4) != 0;
            bus_data_ok = (m_inf.size() != 0) && (($urandom % 2) != 0);
            bus_rdata   = $urandom;
            resp_ready  = ($urandom % 4) != 0;
            flush       = ($urandom % 32) == 0;
            step();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
